// File: rtl/div_pipe_param.sv
`default_nettype none
// ============================================================================
// Module      : div_pipe_param
// Description : Pipelined restoring radix-2 divider (signed/unsigned) with
//               sideband tag, stall and RISC-V style divide-by-zero/overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module div_pipe_param #(
    parameter int WIDTH           = 32,
    parameter int ITERS_PER_STAGE = 4,
    parameter int TAG_W           = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             i_valid,
    input  logic             i_signed,
    input  logic [TAG_W-1:0] i_tag,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int STAGES = WIDTH / ITERS_PER_STAGE;

    localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             sgn;
        logic [WIDTH-1:0] dvd;
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] quo;
        logic [WIDTH-1:0] dsr;
        logic             neg_q;
        logic             neg_r;
        logic             dbz;
        logic             ovf;
        logic [WIDTH-1:0] orig;
    } stage_t;

    stage_t r_stage [STAGES];
    stage_t w_src   [STAGES];
    stage_t w_nxt   [STAGES];
    stage_t w_entry;
    stage_t w_cur;
    stage_t w_last;

    logic             w_dvd_neg;
    logic             w_dsr_neg;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_unused;

    // Operand entry: magnitudes, sign flags and special cases are resolved
    // here so the iterative stages only ever see unsigned values.
    always_comb begin
        w_dvd_neg     = i_signed & i_dividend[WIDTH-1];
        w_dsr_neg     = i_signed & i_divisor[WIDTH-1];
        w_entry       = '0;
        w_entry.valid = i_valid;
        w_entry.tag   = i_tag;
        w_entry.sgn   = i_signed;
        w_entry.dvd   = w_dvd_neg ? (-i_dividend) : i_dividend;
        w_entry.dsr   = w_dsr_neg ? (-i_divisor) : i_divisor;
        w_entry.neg_q = w_dvd_neg ^ w_dsr_neg;
        w_entry.neg_r = w_dvd_neg;
        w_entry.dbz   = (i_divisor == '0);
        w_entry.ovf   = i_signed & (i_dividend == c_min_neg) & (&i_divisor);
        w_entry.orig  = i_dividend;
    end

    always_comb begin
        w_src[0] = w_entry;
        for (int s = 1; s < STAGES; s++) begin
            w_src[s] = r_stage[s-1];
        end
    end

    // Restoring iterations; the compare is WIDTH+1 bits wide so a divisor
    // with its MSB set is handled without losing the shifted-out bit.
    always_comb begin
        w_cur   = '0;
        w_shift = '0;
        w_diff  = '0;
        for (int s = 0; s < STAGES; s++) begin
            w_cur = w_src[s];
            for (int i = 0; i < ITERS_PER_STAGE; i++) begin
                w_shift = {w_cur.rem, w_cur.dvd[WIDTH-1]};
                w_diff  = w_shift - {1'b0, w_cur.dsr};
                if (w_shift >= {1'b0, w_cur.dsr}) begin
                    w_cur.rem = w_diff[WIDTH-1:0];
                    w_cur.quo = {w_cur.quo[WIDTH-2:0], 1'b1};
                end else begin
                    w_cur.rem = w_shift[WIDTH-1:0];
                    w_cur.quo = {w_cur.quo[WIDTH-2:0], 1'b0};
                end
                w_cur.dvd = {w_cur.dvd[WIDTH-2:0], 1'b0};
            end
            w_nxt[s] = w_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                r_stage[s] <= '0;
            end
        end else if (!stall) begin
            for (int s = 0; s < STAGES; s++) begin
                r_stage[s] <= w_nxt[s];
            end
        end
    end

    assign w_last   = r_stage[STAGES-1];
    assign w_unused = ^{w_last.dvd, w_last.dsr};

    always_comb begin
        o_valid     = w_last.valid;
        o_tag       = w_last.tag;
        o_quotient  = (w_last.sgn & w_last.neg_q) ? (-w_last.quo) : w_last.quo;
        o_remainder = (w_last.sgn & w_last.neg_r) ? (-w_last.rem) : w_last.rem;
        if (w_last.dbz) begin
            o_quotient  = '1;
            o_remainder = w_last.orig;
        end else if (w_last.ovf) begin
            o_quotient  = w_last.orig;
            o_remainder = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_pipe_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_pipe_param
// Description : Directed self-checking bench for div_pipe_param (32/4/5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_pipe_param;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        i_valid;
    logic        i_signed;
    logic [4:0]  i_tag;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        o_valid;
    logic [4:0]  o_tag;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;

    int checks = 0;
    int errors = 0;

    div_pipe_param #(
        .WIDTH          (32),
        .ITERS_PER_STAGE(4),
        .TAG_W          (5)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .i_valid    (i_valid),
        .i_signed   (i_signed),
        .i_tag      (i_tag),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_valid    (o_valid),
        .o_tag      (o_tag),
        .o_quotient (o_quotient),
        .o_remainder(o_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op and waits (bounded) for its result; lat counts edges
    // from the capturing edge (1) to the edge that raises o_valid.
    task automatic do_op(input logic sgn, input logic [4:0] tag,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic ov,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic [4:0] t);
        stall      = 1'b0;
        i_valid    = 1'b1;
        i_signed   = sgn;
        i_tag      = tag;
        i_dividend = a;
        i_divisor  = b;
        step();
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin
            step();
            lat++;
        end
        ov = o_valid;
        q  = o_quotient;
        r  = o_remainder;
        t  = o_tag;
        step();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        stall   = 1'b0;
        i_valid = 1'b1;
        i_signed = 1'b0;
        i_tag   = 5'd7;
        i_dividend = 32'd50;
        i_divisor  = 32'd5;
        repeat (3) step();
        i_valid = 1'b0;
        rst     = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", o_valid);
        end
        checks++;
        if (o_quotient !== 32'd0) begin
            errors++;
            $display("FAIL reset_quotient: got %h want 0", o_quotient);
        end
        checks++;
        if (o_remainder !== 32'd0) begin
            errors++;
            $display("FAIL reset_remainder: got %h want 0", o_remainder);
        end
        checks++;
        if (o_tag !== 5'd0) begin
            errors++;
            $display("FAIL reset_tag: got %h want 0", o_tag);
        end
    endtask

    task automatic test_unsigned();
        int          lat;
        logic        ov;
        logic [31:0] q, r;
        logic [4:0]  t;
        do_op(1'b0, 5'd3, 32'd100, 32'd7, lat, ov, q, r, t);
        checks++;
        if (ov !== 1'b1 || lat != 8) begin
            errors++;
            $display("FAIL u100_7_latency: got valid=%b lat=%0d want valid=1 lat=8", ov, lat);
        end
        checks++;
        if (q !== 32'd14 || r !== 32'd2 || t !== 5'd3) begin
            errors++;
            $display("FAIL u100_7_result: got q=%h r=%h t=%0d want q=e r=2 t=3", q, r, t);
        end
        do_op(1'b0, 5'd9, 32'hFFFF_FFFF, 32'h8000_0001, lat, ov, q, r, t);
        checks++;
        if (ov !== 1'b1 || q !== 32'd1 || r !== 32'h7FFF_FFFE || t !== 5'd9) begin
            errors++;
            $display("FAIL u_msb_divisor: got v=%b q=%h r=%h t=%0d want v=1 q=1 r=7ffffffe t=9",
                     ov, q, r, t);
        end
    endtask

    task automatic test_signed();
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic [31:0] eq [4];
        logic [31:0] er [4];
        int          lat;
        logic        ov;
        logic [31:0] q, r;
        logic [4:0]  t;
        ta = '{32'hFFFF_FFF9, 32'd7,        32'hFFFF_FFF9, 32'h8000_0000};
        tb = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1};
        eq = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3,        32'h8000_0000};
        er = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0};
        for (int k = 0; k < 4; k++) begin
            do_op(1'b1, 5'(k + 10), ta[k], tb[k], lat, ov, q, r, t);
            checks++;
            if (ov !== 1'b1 || lat != 8 || q !== eq[k] || r !== er[k] || t !== 5'(k + 10)) begin
                errors++;
                $display("FAIL signed_%0d: got v=%b lat=%0d q=%h r=%h t=%0d want v=1 lat=8 q=%h r=%h t=%0d",
                         k, ov, lat, q, r, t, eq[k], er[k], k + 10);
            end
        end
    endtask

    task automatic test_corners();
        logic        ts [5];
        logic [31:0] ta [5];
        logic [31:0] tb [5];
        logic [31:0] eq [5];
        logic [31:0] er [5];
        int          lat;
        logic        ov;
        logic [31:0] q, r;
        logic [4:0]  t;
        ts = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        ta = '{32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB};
        tb = '{32'd0,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        eq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF};
        er = '{32'h1234_5678, 32'h1234_5678, 32'd0,         32'h8000_0000, 32'hFFFF_FFFB};
        for (int k = 0; k < 5; k++) begin
            do_op(ts[k], 5'(k + 20), ta[k], tb[k], lat, ov, q, r, t);
            checks++;
            if (ov !== 1'b1 || lat != 8 || q !== eq[k] || r !== er[k] || t !== 5'(k + 20)) begin
                errors++;
                $display("FAIL corner_%0d: got v=%b lat=%0d q=%h r=%h t=%0d want v=1 lat=8 q=%h r=%h t=%0d",
                         k, ov, lat, q, r, t, eq[k], er[k], k + 20);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] eq [8];
        logic [31:0] er [8];
        int          eedge [8];
        int          issued = 0;
        int          idx = 0;
        eq    = '{32'd3, 32'd6, 32'd7, 32'd8, 32'd8, 32'd8, 32'd9, 32'd9};
        er    = '{32'd0, 32'd1, 32'd2, 32'd1, 32'd3, 32'd5, 32'd0, 32'd1};
        eedge = '{10, 11, 12, 13, 14, 15, 16, 17};
        for (int e = 0; e < 30; e++) begin
            stall = (e >= 4 && e <= 6);
            if (stall) begin
                i_valid    = 1'b1;
                i_signed   = 1'b0;
                i_tag      = 5'd31;
                i_dividend = 32'd999;
                i_divisor  = 32'd1;
            end else if (issued < 8) begin
                i_valid    = 1'b1;
                i_signed   = 1'b0;
                i_tag      = 5'(issued);
                i_dividend = 32'(10 * issued + 3);
                i_divisor  = 32'(issued + 1);
                issued++;
            end else begin
                i_valid = 1'b0;
            end
            step();
            if (o_valid) begin
                checks++;
                if (idx >= 8) begin
                    errors++;
                    $display("FAIL b2b_extra: got extra result tag=%0d at edge %0d want none", o_tag, e);
                end else if (o_tag !== 5'(idx) || o_quotient !== eq[idx] ||
                             o_remainder !== er[idx] || e != eedge[idx]) begin
                    errors++;
                    $display("FAIL b2b_op%0d: got t=%0d q=%h r=%h edge=%0d want t=%0d q=%h r=%h edge=%0d",
                             idx, o_tag, o_quotient, o_remainder, e, idx, eq[idx], er[idx], eedge[idx]);
                end
                idx++;
            end
        end
        stall   = 1'b0;
        i_valid = 1'b0;
        checks++;
        if (idx != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want 8", idx);
        end
    endtask

    task automatic test_reset_in_flight();
        int          seen = 0;
        int          lat;
        logic        ov;
        logic [31:0] q, r;
        logic [4:0]  t;
        for (int k = 0; k < 5; k++) begin
            i_valid    = 1'b1;
            i_signed   = 1'b0;
            i_tag      = 5'(k + 1);
            i_dividend = 32'd77;
            i_divisor  = 32'd7;
            step();
        end
        i_valid = 1'b0;
        rst     = 1'b1;
        stall   = 1'b1;
        repeat (2) step();
        rst   = 1'b0;
        stall = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (o_valid) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_flush: got %0d valid cycles after reset want 0", seen);
        end
        do_op(1'b0, 5'd4, 32'd9, 32'd3, lat, ov, q, r, t);
        checks++;
        if (ov !== 1'b1 || lat != 8 || q !== 32'd3 || r !== 32'd0 || t !== 5'd4) begin
            errors++;
            $display("FAIL rst_first_op: got v=%b lat=%0d q=%h r=%h t=%0d want v=1 lat=8 q=3 r=0 t=4",
                     ov, lat, q, r, t);
        end
    endtask

    initial begin
        rst        = 1'b1;
        stall      = 1'b0;
        i_valid    = 1'b0;
        i_signed   = 1'b0;
        i_tag      = '0;
        i_dividend = '0;
        i_divisor  = '0;
        #1;
        test_reset();
        test_unsigned();
        test_signed();
        test_corners();
        test_back_to_back();
        test_reset_in_flight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
